// File: rtl/ad9850_serial_rx.sv
// AD9850 serial-load receiver: oversamples W_CLK/FQ_UD/DATA/RESET on clk, tracks
// serial-mode entry, shifts the frame in LSB first and latches it on FQ_UD.
`timescale 1ns/1ps
module ad9850_serial_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int TW_WIDTH    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                w_clk_in,
   input  logic                fq_ud_in,
   input  logic                data_in,
   input  logic                dds_reset_in,
   output logic [TW_WIDTH-1:0] tuning_word,
   output logic [4:0]          phase,
   output logic                power_down,
   output logic [1:0]          ctrl_factory,
   output logic                word_valid,
   output logic                serial_mode,
   output logic [5:0]          bit_count,
   output logic                err_short,
   output logic                err_long
);

   localparam int         FRAME_W   = TW_WIDTH + 8;
   localparam logic [5:0] FRAME_LEN = 6'(FRAME_W);

   typedef enum logic [1:0] {WAIT_WCLK, WAIT_FQUD, SERIAL} state_t;

   state_t state_q, state_nx;

   logic [SYNC_STAGES-1:0] w_clk_p0, fq_ud_p0, data_p0, dds_rst_p0;
   logic                   w_clk_p1, fq_ud_p1;
   logic                   w_clk_s, fq_ud_s, data_s, dds_rst_s;
   logic                   w_clk_rise, fq_ud_rise;

   logic [FRAME_W-1:0]     shreg, shreg_nx;
   logic [5:0]             cnt_nx;
   logic                   overrun;

   // Stage p0: input synchronizers; stage p1: delayed copies for rising-edge detect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_clk_p0   <= '0;
         fq_ud_p0   <= '0;
         data_p0    <= '0;
         dds_rst_p0 <= '0;
         w_clk_p1   <= 1'b0;
         fq_ud_p1   <= 1'b0;
      end else begin
         w_clk_p0   <= {w_clk_p0[SYNC_STAGES-2:0], w_clk_in};
         fq_ud_p0   <= {fq_ud_p0[SYNC_STAGES-2:0], fq_ud_in};
         data_p0    <= {data_p0[SYNC_STAGES-2:0], data_in};
         dds_rst_p0 <= {dds_rst_p0[SYNC_STAGES-2:0], dds_reset_in};
         w_clk_p1   <= w_clk_s;
         fq_ud_p1   <= fq_ud_s;
      end
   end

   assign w_clk_s    = w_clk_p0[SYNC_STAGES-1];
   assign fq_ud_s    = fq_ud_p0[SYNC_STAGES-1];
   assign data_s     = data_p0[SYNC_STAGES-1];
   assign dds_rst_s  = dds_rst_p0[SYNC_STAGES-1];
   assign w_clk_rise = w_clk_s & ~w_clk_p1;
   assign fq_ud_rise = fq_ud_s & ~fq_ud_p1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= WAIT_WCLK;
      else       state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      if (dds_rst_s) begin
         state_nx = WAIT_WCLK;
      end else begin
         case (state_q)
            WAIT_WCLK: if (w_clk_rise) state_nx = WAIT_FQUD;
            WAIT_FQUD: if (fq_ud_rise) state_nx = SERIAL;
            SERIAL:    state_nx = SERIAL;
            default:   state_nx = WAIT_WCLK;
         endcase
      end
   end

   assign serial_mode = (state_q == SERIAL);

   // The shifted bit is folded in before FQ_UD is judged, so a simultaneous
   // W_CLK/FQ_UD pair commits against the incremented count.
   always_comb begin
      shreg_nx = shreg;
      cnt_nx   = bit_count;
      overrun  = 1'b0;
      if (serial_mode && !dds_rst_s && w_clk_rise) begin
         if (bit_count < FRAME_LEN) begin
            shreg_nx[bit_count] = data_s;
            cnt_nx              = bit_count + 6'd1;
         end else begin
            overrun = 1'b1;
         end
      end
   end

   // Stage p2: frame shift, commit and error strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg        <= '0;
         bit_count    <= '0;
         tuning_word  <= '0;
         phase        <= '0;
         power_down   <= 1'b0;
         ctrl_factory <= '0;
         word_valid   <= 1'b0;
         err_short    <= 1'b0;
         err_long     <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         err_short  <= 1'b0;
         err_long   <= 1'b0;
         if (dds_rst_s) begin
            shreg        <= '0;
            bit_count    <= '0;
            tuning_word  <= '0;
            phase        <= '0;
            power_down   <= 1'b0;
            ctrl_factory <= '0;
         end else if (serial_mode) begin
            shreg     <= shreg_nx;
            bit_count <= cnt_nx;
            err_long  <= overrun;
            if (fq_ud_rise) begin
               bit_count <= '0;
               if (cnt_nx == FRAME_LEN) begin
                  tuning_word  <= shreg_nx[TW_WIDTH-1:0];
                  ctrl_factory <= shreg_nx[TW_WIDTH+1:TW_WIDTH];
                  power_down   <= shreg_nx[TW_WIDTH+2];
                  phase        <= shreg_nx[TW_WIDTH+7:TW_WIDTH+3];
                  word_valid   <= 1'b1;
               end else begin
                  err_short <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ad9850_serial_rx.sv
// Randomized bench for ad9850_serial_rx: a pin-level programmer drives frames while a
// frame-level model predicts commits/errors into a queue that a monitor drains.
`timescale 1ns/1ps
module tb_ad9850_serial_rx;

   localparam int EV_COMMIT = 0;
   localparam int EV_SHORT  = 1;
   localparam int EV_LONG   = 2;

   logic        clk = 1'b0;
   logic        reset, w_clk_in, fq_ud_in, data_in, dds_reset_in;
   logic [31:0] tuning_word;
   logic [4:0]  phase;
   logic        power_down;
   logic [1:0]  ctrl_factory;
   logic        word_valid, serial_mode, err_short, err_long;
   logic [5:0]  bit_count;

   ad9850_serial_rx #(.SYNC_STAGES(2), .TW_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .w_clk_in(w_clk_in), .fq_ud_in(fq_ud_in),
      .data_in(data_in), .dds_reset_in(dds_reset_in), .tuning_word(tuning_word),
      .phase(phase), .power_down(power_down), .ctrl_factory(ctrl_factory),
      .word_valid(word_valid), .serial_mode(serial_mode), .bit_count(bit_count),
      .err_short(err_short), .err_long(err_long)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [39:0] frame;
   } ev_t;

   ev_t  exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Frame-level model: 0 = awaiting W_CLK, 1 = awaiting FQ_UD, 2 = serial
   int          m_stage = 0;
   logic        m_bits[$];
   logic [31:0] m_tw = '0;
   logic [4:0]  m_ph = '0;
   logic        m_pd = 1'b0;
   logic [1:0]  m_cf = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pop_check(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d with nothing expected at %0t", kind, $time);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 64'(kind), 64'(e.kind));
         if (kind == EV_COMMIT && e.kind == EV_COMMIT) begin
            check("commit_tw", 64'(tuning_word), 64'(e.frame[31:0]));
            check("commit_phase", 64'(phase), 64'(e.frame[39:35]));
            check("commit_pd", 64'(power_down), 64'(e.frame[34]));
            check("commit_cf", 64'(ctrl_factory), 64'(e.frame[33:32]));
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (!reset) begin
         if (err_long)   pop_check(EV_LONG);
         if (err_short)  pop_check(EV_SHORT);
         if (word_valid) pop_check(EV_COMMIT);
      end
   end

   task automatic model_clear();
      m_stage = 0;
      m_bits.delete();
      m_tw = '0; m_ph = '0; m_pd = 1'b0; m_cf = '0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wclk_pulse(input logic b, input int hi, input int lo);
      ev_t e;
      if (m_stage == 0) m_stage = 1;
      else if (m_stage == 2) begin
         if (m_bits.size() < 40) m_bits.push_back(b);
         else begin
            e.kind = EV_LONG; e.frame = '0;
            exp_q.push_back(e);
         end
      end
      data_in  = b;
      w_clk_in = 1'b1;
      settle(hi);
      w_clk_in = 1'b0;
      settle(lo);
   endtask

   task automatic fq_pulse(input int hi, input int lo);
      ev_t e;
      if (m_stage == 1) m_stage = 2;
      else if (m_stage == 2) begin
         e.frame = '0;
         if (m_bits.size() == 40) begin
            for (int i = 0; i < 40; i++) e.frame[i] = m_bits[i];
            e.kind = EV_COMMIT;
            m_tw = e.frame[31:0];
            m_cf = e.frame[33:32];
            m_pd = e.frame[34];
            m_ph = e.frame[39:35];
         end else begin
            e.kind = EV_SHORT;
         end
         exp_q.push_back(e);
         m_bits.delete();
      end
      fq_ud_in = 1'b1;
      settle(hi);
      fq_ud_in = 1'b0;
      settle(lo);
   endtask

   task automatic send_bits(input logic [39:0] f, input int nbits, input bit rand_timing);
      logic b;
      for (int i = 0; i < nbits; i++) begin
         b = (i < 40) ? f[i] : 1'($urandom);
         if (rand_timing) wclk_pulse(b, int'($urandom_range(2, 4)), int'($urandom_range(2, 4)));
         else             wclk_pulse(b, 2, 2);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_tw"}, 64'(tuning_word), 64'(m_tw));
      check({tag, "_phase"}, 64'(phase), 64'(m_ph));
      check({tag, "_pd"}, 64'(power_down), 64'(m_pd));
      check({tag, "_cf"}, 64'(ctrl_factory), 64'(m_cf));
      check({tag, "_serial"}, 64'(serial_mode), 64'(m_stage == 2));
      check({tag, "_count"}, 64'(bit_count), 64'(m_bits.size()));
   endtask

   task automatic enter_serial();
      wclk_pulse(1'b0, 2, 2);
      settle(4);
      check("entry_wait_fqud", 64'(serial_mode), 64'(0));
      fq_pulse(2, 2);
      settle(6);
      check_state("entry");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] fr;
      int          nb;
      reset = 1'b1; w_clk_in = 1'b0; fq_ud_in = 1'b0; data_in = 1'b0; dds_reset_in = 1'b0;
      settle(5);
      check("rst_word_valid", 64'(word_valid), 64'(0));
      check("rst_err_short", 64'(err_short), 64'(0));
      check("rst_err_long", 64'(err_long), 64'(0));
      check_state("rst");
      reset = 1'b0;
      settle(4);

      enter_serial();
      send_bits({8'h00, 32'h147AE147}, 40, 1'b0);
      fq_pulse(2, 2); settle(6);
      check_state("frame1");

      send_bits({8'h2C, 32'h0A3D70A3}, 40, 1'b0);
      fq_pulse(2, 2); settle(6);
      check_state("frame2");

      send_bits({8'h00, $urandom()}, 32, 1'b1);
      fq_pulse(2, 2); settle(6);
      check_state("short");

      send_bits({8'($urandom()), $urandom()}, 42, 1'b1);
      fq_pulse(2, 2); settle(6);
      check_state("long");

      for (int k = 0; k < 8; k++) begin
         fr = {8'($urandom()), $urandom()};
         nb = (k < 4) ? 40 : int'($urandom_range(36, 42));
         send_bits(fr, nb, 1'b1);
         fq_pulse(int'($urandom_range(2, 4)), int'($urandom_range(2, 4)));
      end
      settle(6);
      check_state("random");

      // Over-fast W_CLK: capture count is only bounded, so these bits bypass the model
      for (int i = 0; i < 20; i++) begin
         data_in = 1'($urandom());
         w_clk_in = 1'b1; settle(1);
         w_clk_in = 1'b0; settle(1);
      end
      settle(6);
      check("fast_count_bound", 64'(bit_count <= 6'd20), 64'(1));
      fq_pulse(2, 2); settle(6);
      check_state("fast_flush");
      send_bits({8'($urandom()), $urandom()}, 40, 1'b0);
      fq_pulse(2, 2); settle(6);
      check_state("slow_exact");

      send_bits({8'($urandom()), $urandom()}, 20, 1'b1);
      dds_reset_in = 1'b1;
      model_clear();
      settle(6);
      dds_reset_in = 1'b0;
      settle(6);
      check_state("ddsrst");
      send_bits({8'h2C, 32'h0A3D70A3}, 40, 1'b1);
      settle(6);
      check_state("ddsrst_noentry");
      fq_pulse(2, 2); settle(6);
      check_state("ddsrst_entry");
      send_bits({8'($urandom()), $urandom()}, 40, 1'b1);
      fq_pulse(2, 2); settle(6);
      check_state("ddsrst_frame");

      send_bits({8'($urandom()), $urandom()}, 10, 1'b1);
      settle(2);
      reset = 1'b1;
      model_clear();
      settle(3);
      reset = 1'b0;
      settle(4);
      check_state("midreset");
      enter_serial();
      send_bits({8'($urandom()), $urandom()}, 40, 1'b1);
      fq_pulse(2, 2); settle(10);
      check_state("final");
      check("queue_empty", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
